// File: rtl/mux_scan_n_to_one.sv
// Registered N-to-one channel mux with manual select and an auto-scan mode.
// The scan mode has a programmable dwell time and a hold control.
module mux_scan_n_to_one #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] DIN,
    input  logic [SEL_W-1:0]          SEL,
    input  logic                      MODE,
    input  logic                      HOLD,
    output logic [WIDTH-1:0]          DOUT,
    output logic [SEL_W-1:0]          CUR_SEL,
    output logic                      WRAP,
    output logic                      SEL_ERR,
    output logic                      VALID
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
    // One bit wider so CHANNELS == 2**SEL_W does not wrap to zero.
    localparam logic [SEL_W:0]   NUM_CH   = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t                             state, state_next;
    logic [CNT_W-1:0]                   cnt, cnt_next;
    logic [SEL_W-1:0]                   next_sel;
    logic [WIDTH-1:0]                   dout_next;
    logic                               wrap_next, err_next;
    logic [CHANNELS-1:0][WIDTH-1:0]     chan;

    assign chan = DIN;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = MODE ? SCAN : MANUAL;
    end

    always_comb begin
        next_sel  = CUR_SEL;
        cnt_next  = '0;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (!MODE) begin
            if ({1'b0, SEL} < NUM_CH) next_sel = SEL;
            else                      err_next = 1'b1;
        end else if (state == SCAN) begin
            if (HOLD) begin
                cnt_next = cnt;
            end else if (cnt == CNT_LAST) begin
                if (CUR_SEL == SEL_LAST) begin
                    next_sel  = '0;
                    wrap_next = 1'b1;
                end else begin
                    next_sel = CUR_SEL + 1'b1;
                end
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
        // Entering SCAN from IDLE/MANUAL keeps CUR_SEL with a fresh dwell count.
    end

    // Decoded select rather than a dynamic index: never yields X.
    always_comb begin
        dout_next = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (next_sel == SEL_W'(k)) dout_next = chan[k];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT    <= '0;
            CUR_SEL <= '0;
            cnt     <= '0;
            WRAP    <= 1'b0;
            SEL_ERR <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            DOUT    <= dout_next;
            CUR_SEL <= next_sel;
            cnt     <= cnt_next;
            WRAP    <= wrap_next;
            SEL_ERR <= err_next;
            VALID   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_scan_n_to_one.sv
// Directed bench for mux_scan_n_to_one: a 4-channel and a 3-channel instance
// driven in lockstep, checked against a cycle model through scoreboard queues.
module tb_mux_scan_n_to_one;

    localparam int W  = 4;
    localparam int DW = 3;

    logic        clk = 1'b0;
    logic        rst, mode, hold;
    logic [1:0]  sel;
    logic [15:0] din;

    logic [W-1:0] dout_a, dout_b;
    logic [1:0]   cs_a, cs_b;
    logic         wrap_a, wrap_b, err_a, err_b, valid_a, valid_b;

    always #5 clk = ~clk;

    mux_scan_n_to_one #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .DWELL(DW)) dut_a (
        .CLK(clk), .RST(rst), .DIN(din), .SEL(sel), .MODE(mode), .HOLD(hold),
        .DOUT(dout_a), .CUR_SEL(cs_a), .WRAP(wrap_a), .SEL_ERR(err_a), .VALID(valid_a)
    );

    mux_scan_n_to_one #(.WIDTH(W), .CHANNELS(3), .SEL_W(2), .DWELL(DW)) dut_b (
        .CLK(clk), .RST(rst), .DIN(din[11:0]), .SEL(sel), .MODE(mode), .HOLD(hold),
        .DOUT(dout_b), .CUR_SEL(cs_b), .WRAP(wrap_b), .SEL_ERR(err_b), .VALID(valid_b)
    );

    typedef struct packed {
        logic [3:0] dout;
        logic [1:0] cur_sel;
        logic       wrap;
        logic       sel_err;
        logic       valid;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Model state per instance; st: 0 idle, 1 manual, 2 scan.
    int m_sel[2];
    int m_cnt[2];
    int m_st[2];

    int vectors     = 0;
    int miscompares = 0;
    int step_no     = 0;

    function automatic exp_t model(int i, int ch, logic r, logic m, logic h,
                                   logic [1:0] s, logic [15:0] d);
        exp_t e;
        e = '0;
        if (r) begin
            m_sel[i] = 0;
            m_cnt[i] = 0;
            m_st[i]  = 0;
            return e;
        end
        e.valid = 1'b1;
        if (!m) begin
            if (int'(s) < ch) m_sel[i] = int'(s);
            else              e.sel_err = 1'b1;
            m_cnt[i] = 0;
            m_st[i]  = 1;
        end else if (m_st[i] != 2) begin
            m_cnt[i] = 0;
            m_st[i]  = 2;
        end else if (!h) begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == DW) begin
                m_cnt[i] = 0;
                m_sel[i] = (m_sel[i] + 1) % ch;
                e.wrap   = (m_sel[i] == 0);
            end
        end
        e.cur_sel = 2'(m_sel[i]);
        e.dout    = d[m_sel[i]*4 +: 4];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL step %0d %s: observed %0h expected %0h", step_no, tag, act, exp);
        end
    endtask

    task automatic pop_cmp(input string pfx, ref exp_t q[$], input logic [3:0] d,
                           input logic [1:0] c, input logic w, input logic er, input logic v);
        exp_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL step %0d %s.queue: observed empty expected entry", step_no, pfx);
            return;
        end
        e = q.pop_front();
        chk({pfx, ".dout"},    {4'h0, d},    {4'h0, e.dout});
        chk({pfx, ".cur_sel"}, {6'h0, c},    {6'h0, e.cur_sel});
        chk({pfx, ".wrap"},    {7'h0, w},    {7'h0, e.wrap});
        chk({pfx, ".sel_err"}, {7'h0, er},   {7'h0, e.sel_err});
        chk({pfx, ".valid"},   {7'h0, v},    {7'h0, e.valid});
    endtask

    task automatic step(input logic r, input logic m, input logic h,
                        input logic [1:0] s, input logic [15:0] d);
        rst  = r;
        mode = m;
        hold = h;
        sel  = s;
        din  = d;
        q_a.push_back(model(0, 4, r, m, h, s, d));
        q_b.push_back(model(1, 3, r, m, h, s, d));
        @(posedge clk);
        #1;
        step_no++;
        pop_cmp("a", q_a, dout_a, cs_a, wrap_a, err_a, valid_a);
        pop_cmp("b", q_b, dout_b, cs_b, wrap_b, err_b, valid_b);
    endtask

    localparam logic [15:0] DIN0 = 16'hDCBA;
    localparam logic [15:0] DIN7 = 16'hDC7A;

    initial begin
        rst = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd0; din = DIN0;

        // Reset, then manual sweep
        step(1, 0, 0, 0, DIN0);
        step(1, 1, 1, 3, DIN0);
        chk("rst.dout",  {4'h0, dout_a}, 8'h00);
        chk("rst.valid", {7'h0, valid_a}, 8'h00);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 2'(k), DIN0);
        chk("man.dout",   {4'h0, dout_a}, 8'h0D);
        chk("man.cs",     {6'h0, cs_a},   8'h03);
        chk("man.b_err",  {7'h0, err_b},  8'h01);
        chk("man.b_cs",   {6'h0, cs_b},   8'h02);

        // Scan with wrap from channel 0, HOLD ignored in manual
        step(0, 0, 1, 0, DIN0);
        for (int k = 0; k < 15; k++) step(0, 1, 0, 0, DIN0);

        // Hold on channel 1 after one dwell cycle there
        step(0, 0, 0, 0, DIN0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, DIN0);
        step(0, 1, 1, 0, DIN7);
        chk("hold.cs",   {6'h0, cs_a},   8'h01);
        chk("hold.dout", {4'h0, dout_a}, 8'h07);
        for (int k = 0; k < 4; k++) step(0, 1, 1, 0, DIN7);
        step(0, 1, 0, 0, DIN7);
        chk("rel1.cs", {6'h0, cs_a}, 8'h01);
        step(0, 1, 0, 0, DIN7);
        chk("rel2.cs", {6'h0, cs_a}, 8'h02);

        // Out-of-range select (rejected only by the 3-channel instance)
        step(0, 0, 0, 1, DIN0);
        step(0, 0, 0, 3, DIN0);
        chk("oor.b_cs",   {6'h0, cs_b},   8'h01);
        chk("oor.b_dout", {4'h0, dout_b}, 8'h0B);
        step(0, 0, 0, 3, DIN0);
        step(0, 0, 0, 2, DIN0);
        chk("oor.b_err_clr", {7'h0, err_b}, 8'h00);

        // Mode switch mid-dwell
        step(0, 1, 0, 2, DIN0);
        step(0, 1, 0, 2, DIN0);
        step(0, 0, 0, 0, DIN0);
        chk("sw.cs",   {6'h0, cs_a},   8'h00);
        chk("sw.dout", {4'h0, dout_a}, 8'h0A);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, DIN0);

        // Reset mid-scan
        step(0, 0, 0, 3, DIN0);
        step(0, 1, 0, 0, DIN0);
        step(0, 1, 0, 0, DIN0);
        step(1, 1, 0, 0, DIN0);
        chk("rms.dout",  {4'h0, dout_a},  8'h00);
        chk("rms.cs",    {6'h0, cs_a},    8'h00);
        chk("rms.valid", {7'h0, valid_a}, 8'h00);
        step(0, 1, 0, 0, DIN0);
        chk("rms.restart", {4'h0, dout_a}, 8'h0A);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, DIN0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
